// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared opcode, state and writeback-select encodings for the exec sequencer
package exec_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/exec_opdecode.sv
// rtl/exec_opdecode.sv - combinational RV32I opcode classifier feeding the per-instruction registers
module exec_opdecode
  import exec_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       alu_src,
  output logic [1:0] wb_sel,
  output logic       needs_mem,
  output logic       mem_we,
  output logic       is_branch,
  output logic       legal
);

  always_comb begin
    alu_src   = 1'b0;
    wb_sel    = WB_ALU;
    needs_mem = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OPC_OP: alu_src = 1'b0;
      OPC_OP_IMM, OPC_LUI, OPC_AUIPC: alu_src = 1'b1;
      OPC_LOAD: begin
        alu_src   = 1'b1;
        wb_sel    = WB_MEM;
        needs_mem = 1'b1;
      end
      OPC_STORE: begin
        alu_src   = 1'b1;
        needs_mem = 1'b1;
        mem_we    = 1'b1;
      end
      OPC_BRANCH: is_branch = 1'b1;
      OPC_JAL, OPC_JALR: begin
        alu_src = 1'b1;
        wb_sel  = WB_PC4;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control FSM
module exec_sequencer
  import exec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_load,
  output logic       alu_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       pc_update,
  output logic       illegal,
  output logic [2:0] state
);

  state_t     state_q, state_d;
  logic       alu_src_q, alu_src_d;
  logic [1:0] wb_sel_q, wb_sel_d;
  logic       dmem_we_q, dmem_we_d;
  logic       needs_mem_q, needs_mem_d;
  logic       is_branch_q, is_branch_d;
  logic       illegal_q, illegal_d;

  logic       dec_alu_src;
  logic [1:0] dec_wb_sel;
  logic       dec_needs_mem;
  logic       dec_mem_we;
  logic       dec_is_branch;
  logic       dec_legal;

  exec_opdecode u_opdecode (
    .opcode    (opcode),
    .alu_src   (dec_alu_src),
    .wb_sel    (dec_wb_sel),
    .needs_mem (dec_needs_mem),
    .mem_we    (dec_mem_we),
    .is_branch (dec_is_branch),
    .legal     (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      alu_src_q   <= 1'b0;
      wb_sel_q    <= WB_ALU;
      dmem_we_q   <= 1'b0;
      needs_mem_q <= 1'b0;
      is_branch_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_src_q   <= alu_src_d;
      wb_sel_q    <= wb_sel_d;
      dmem_we_q   <= dmem_we_d;
      needs_mem_q <= needs_mem_d;
      is_branch_q <= is_branch_d;
      illegal_q   <= illegal_d;
    end
  end

  // Instruction class is captured once in DECODE so later states never look at opcode.
  always_comb begin
    state_d     = state_q;
    alu_src_d   = alu_src_q;
    wb_sel_d    = wb_sel_q;
    dmem_we_d   = dmem_we_q;
    needs_mem_d = needs_mem_q;
    is_branch_d = is_branch_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_d   = dec_alu_src;
        wb_sel_d    = dec_wb_sel;
        dmem_we_d   = dec_mem_we;
        needs_mem_d = dec_needs_mem;
        is_branch_d = dec_is_branch;
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (is_branch_q)      state_d = ST_FETCH;
        else if (needs_mem_q) state_d = ST_MEM;
        else                  state_d = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ready) state_d = dmem_we_q ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Requests and strobes are forced low during the reset cycle, whatever state is held.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_load   = 1'b0;
    reg_write = 1'b0;
    pc_update = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ready;
        end
        ST_EXEC: pc_update = is_branch_q;
        ST_MEM: begin
          dmem_req  = 1'b1;
          dmem_we   = dmem_we_q;
          pc_update = dmem_ready & dmem_we_q;
        end
        ST_WB: begin
          reg_write = 1'b1;
          pc_update = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_src = alu_src_q;
  assign wb_sel  = wb_sel_q;
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - scoreboard bench: per-instruction expectations queued at issue, compared at retire
module tb_exec_sequencer;
  import exec_pkg::*;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_load;
  logic       alu_src;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       pc_update;
  logic       illegal;
  logic [2:0] state;

  exec_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir_load    (ir_load),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .pc_update  (pc_update),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    int          rw;
    int          irl;
    int          memc;
    int          alu_ok;
    int          we_ok;
    logic        alu;
    logic        we;
    logic [1:0]  wb;
    logic [47:0] trace;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [6:0] op, input int iwait, input int dwait);
    exp_t       e;
    logic       mem, rw;
    logic [1:0] wb;
    e.alu = 1'b1; e.we = 1'b0; mem = 1'b0; rw = 1'b1; wb = 2'b00;
    case (op)
      OPC_OP:             e.alu = 1'b0;
      OPC_LOAD:           begin mem = 1'b1; wb = 2'b01; end
      OPC_STORE:          begin mem = 1'b1; e.we = 1'b1; rw = 1'b0; end
      OPC_BRANCH:         begin e.alu = 1'b0; rw = 1'b0; end
      OPC_JAL, OPC_JALR:  wb = 2'b10;
      default: ;
    endcase
    e.trace = '0;
    e.cycles = 0;
    for (int i = 0; i <= iwait; i++) begin e.trace = {e.trace[44:0], ST_FETCH}; e.cycles++; end
    e.trace = {e.trace[44:0], ST_DECODE}; e.cycles++;
    e.trace = {e.trace[44:0], ST_EXEC};   e.cycles++;
    if (mem)
      for (int i = 0; i <= dwait; i++) begin e.trace = {e.trace[44:0], ST_MEM}; e.cycles++; end
    if (rw) begin e.trace = {e.trace[44:0], ST_WB}; e.cycles++; end
    e.rw     = rw ? 1 : 0;
    e.irl    = 1;
    e.memc   = mem ? dwait + 1 : 0;
    e.alu_ok = 1 + e.memc + e.rw;
    e.we_ok  = e.memc;
    e.wb     = rw ? wb : 2'b00;
    return e;
  endfunction

  // Acts as both memories; the instruction retires on its pc_update strobe.
  task automatic run_instr(input string tag, input logic [6:0] op, input int iwait, input int dwait);
    exp_t cur, o, e;
    int   fc, mc;
    logic done;
    cur = model(op, iwait, dwait);
    sb.push_back(cur);
    opcode = op;
    o = '{cycles: 0, rw: 0, irl: 0, memc: 0, alu_ok: 0, we_ok: 0,
          alu: 1'b0, we: 1'b0, wb: 2'b00, trace: '0};
    fc = 0; mc = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      if (state == ST_FETCH) begin imem_ready = (fc == iwait); fc++; end
      if (state == ST_MEM)   begin dmem_ready = (mc == dwait); mc++; end
      #1;
      o.cycles++;
      o.trace = {o.trace[44:0], state};
      if (ir_load) o.irl++;
      if (reg_write) begin o.rw++; o.wb = wb_sel; end
      if ((state == ST_EXEC || state == ST_MEM || state == ST_WB) && alu_src == cur.alu) o.alu_ok++;
      if (dmem_req) begin
        o.memc++;
        if (dmem_we == cur.we) o.we_ok++;
      end
      if (pc_update) done = 1'b1;
    end
    e = sb.pop_front();
    chk({tag, "_retired"}, done, 1);
    chk({tag, "_cycles"}, o.cycles, e.cycles);
    chk({tag, "_trace"}, o.trace, e.trace);
    chk({tag, "_ir_load"}, o.irl, e.irl);
    chk({tag, "_reg_write"}, o.rw, e.rw);
    chk({tag, "_wb_sel"}, o.wb, e.wb);
    chk({tag, "_alu_src"}, o.alu_ok, e.alu_ok);
    chk({tag, "_dmem_req"}, o.memc, e.memc);
    chk({tag, "_dmem_we"}, o.we_ok, e.we_ok);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; opcode = OPC_OP; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", state, 3'd0);
    chk("rst_strobes", {imem_req, dmem_req, ir_load, pc_update, reg_write, dmem_we}, 6'b0);
    chk("rst_regs", {alu_src, wb_sel, illegal}, 4'b0);
    rst = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("imem_req_rise", imem_req, 1);

    run_instr("opimm", OPC_OP_IMM, 0, 0);
    run_instr("load_w3", OPC_LOAD, 0, 3);
    run_instr("store", OPC_STORE, 0, 0);
    run_instr("op", OPC_OP, 0, 0);
    run_instr("branch", OPC_BRANCH, 0, 0);
    run_instr("lui_iw2", OPC_LUI, 2, 0);
    run_instr("auipc", OPC_AUIPC, 0, 0);
    run_instr("jal", OPC_JAL, 0, 0);
    run_instr("jalr", OPC_JALR, 1, 0);
    run_instr("store_w2", OPC_STORE, 0, 2);
    run_instr("load", OPC_LOAD, 0, 0);

    opcode = 7'b1111111;
    for (int i = 0; i < 10 && state != ST_TRAP; i++) begin
      @(negedge clk);
      imem_ready = 1'b1;
      #1;
    end
    chk("trap_entry", state, ST_TRAP);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("trap_hold", {state, illegal, imem_req, dmem_req, ir_load, pc_update, reg_write, dmem_we},
          {3'd5, 1'b1, 6'b0});
    end
    rst = 1'b1; imem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("trap_cleared", {state, illegal, imem_req}, {3'd0, 1'b0, 1'b1});

    opcode = OPC_LOAD;
    for (int i = 0; i < 10 && state != ST_MEM; i++) begin
      @(negedge clk);
      imem_ready = 1'b1; dmem_ready = 1'b0;
      #1;
    end
    chk("mem_wait_req", {state, dmem_req}, {3'd3, 1'b1});
    rst = 1'b1; imem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mem_rst", {state, dmem_req, alu_src}, {3'd0, 1'b0, 1'b0});
    run_instr("after_rst", OPC_OP_IMM, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the ALU operand-select line into the ALU operand mux, the instruction-register and PC update strobes, and the register-file write enable. It also runs ready/request handshakes with instruction and data memory.

## Interface
Parameters:
- none; XLEN is fixed at 32 and the opcode field is fixed at 7 bits.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] of the latched instruction register, valid from DECODE onward
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory completed the access this cycle
- imem_req  out  1  fetch request, held until accepted
- dmem_req  out  1  data access request, held until accepted
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
- ir_load  out  1  one-cycle strobe: latch the fetched instruction
- alu_src  out  1  to ALU operand mux: 1 = immediate, 0 = rs2 register data
- reg_write  out  1  register-file write enable, one cycle
- wb_sel  out  2  writeback source: 00 = ALU, 01 = memory, 10 = pc+4
- pc_update  out  1  one-cycle strobe: PC takes its next value
- illegal  out  1  sticky unsupported-opcode flag
- state  out  3  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 are unreachable; if entered, go to FETCH.
- FETCH: imem_req=1.
  - If imem_ready=1: ir_load=1 that cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify the opcode and register alu_src and wb_sel. Both registers hold until the next DECODE. Next state is EXEC, or TRAP if the opcode is unsupported.
- EXEC routing by opcode class:
  - OP 0110011: alu_src=0, next WB, wb_sel=00.
  - OP-IMM 0010011, LUI 0110111, AUIPC 0010111: alu_src=1, next WB, wb_sel=00.
  - LOAD 0000011: alu_src=1, next MEM, dmem_we=0, wb_sel=01.
  - STORE 0100011: alu_src=1, next MEM, dmem_we=1.
  - BRANCH 1100011: alu_src=0. pc_update=1 in EXEC, next FETCH.
  - JAL 1101111, JALR 1100111: alu_src=1, next WB, wb_sel=10.
- MEM: dmem_req=1 with dmem_we as registered.
  - Stay in MEM until dmem_ready=1.
  - Then a load goes to WB.
  - A store pulses pc_update in its completing cycle and goes to FETCH.
- WB: reg_write=1 and pc_update=1 for exactly one cycle, next FETCH.
- TRAP: illegal=1. All request and strobe outputs are 0. Stay in TRAP until rst.
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.

## Timing
- Reset values:
  - state=FETCH.
  - alu_src=0, wb_sel=00, dmem_we=0, illegal=0.
  - All strobes and requests are 0 during the reset cycle.
  - imem_req rises the first cycle after rst deasserts.
- Outputs:
  - imem_req, dmem_req and dmem_we are decoded from state and registered fields.
  - ir_load is combinational on imem_ready.
  - No output depends combinationally on opcode.
- Minimum latency with zero-wait memories:
  - ALU and jump instructions: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Wait states add one cycle per cycle of ready=0. Requests stay high and dmem_we stays stable throughout.
- alu_src is stable from EXEC through the end of MEM/WB for each instruction.
- rst asserted in any state, mid-handshake included, gives FETCH on the next edge with reset values. The outstanding request is dropped without completion.
- rst overrides TRAP.

## Structure
- Shared package `exec_pkg`:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
  - state encoding.
  - wb_sel encoding.
- Sub-module `exec_opdecode`: combinational opcode classifier. Outputs are alu_src, wb_sel, needs_mem, mem_we, is_branch and legal.
- exec_sequencer holds the FSM and the per-instruction registers.

## Test plan
- OP-IMM 0010011, zero-wait memory:
  - states 0,1,2,4,0.
  - alu_src=1 from EXEC through WB.
  - reg_write and pc_update pulse in cycle 4.
  - wb_sel=00.
- LOAD, dmem_ready held low 3 cycles in MEM:
  - dmem_req=1 and dmem_we=0 for 4 cycles.
  - Then WB with wb_sel=01.
  - Total 8 cycles.
- STORE then OP 0110011, back to back:
  - Store: pc_update on the dmem_ready cycle, no reg_write.
  - OP: alu_src=0 in EXEC.
- BRANCH 1100011: pc_update in EXEC, no reg_write, return to FETCH after 3 cycles.
- Opcode 1111111:
  - TRAP, illegal=1 held for 20 cycles with toggling ready inputs.
  - rst clears it and imem_req returns.
- rst in MEM with dmem_req=1:
  - next cycle state=0, dmem_req=0, alu_src=0.
  - The following instruction fetch completes normally.
